snn_core_param: RTL and testbench

- Parametrised successor of the fixed 784-32-10 inference core: a two-layer fully-connected network engine with configurable input, hidden and output layer sizes.
- Sequences the MAC over external synchronous weight and activation-LUT memories, holds hidden activations internally, and computes argmax on the fly.
- Drives a start/busy/done handshake toward the top-level controller.

---
 rtl/snn_pkg.sv | 39 +++
 rtl/snn_mac_sat.sv | 40 ++++
 rtl/snn_core_param.sv | 192 +++++++++++++++++++
 tb/tb_snn_core_param.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the parametrised two-layer SNN inference core:
// FSM encoding, fixed-point constants and accumulator saturation.
package snn_pkg;

    typedef enum logic [3:0] {
        IDLE,
        H_MAC,
        H_DRAIN,
        H_SAT,
        H_LUT,
        H_WR,
        O_MAC,
        O_DRAIN,
        O_SAT,
        O_LUT,
        O_WR,
        DONE
    } state_t;

    localparam int         LUT_OFFSET = 1024;
    localparam int         Q17_HI     = 17;
    localparam int         Q_LO       = 7;
    localparam logic [7:0] INPUT_ONE  = 8'h7F;
    localparam int         SAT_W      = 64;

    // The accumulator arrives sign-extended to SAT_W bits, so testing the bits
    // above Q17_HI against the sign is the same as testing acc[ACC_W-2:17].
    function automatic logic [10:0] saturate(input logic signed [SAT_W-1:0] acc);
        logic [10:0] r;
        if (!acc[SAT_W-1] && (acc[SAT_W-2:Q17_HI] != '0))
            r = 11'h3FF;
        else if (acc[SAT_W-1] && (acc[SAT_W-2:Q17_HI] != '1))
            r = 11'h400;
        else
            r = acc[Q17_HI:Q_LO];
        return r;
    endfunction

endpackage

// File: rtl/snn_mac_sat.sv
// Signed 8x8 multiply-accumulate with one-cycle-delayed accumulate enable
// (matching the 1-cycle memory latency) and an 11-bit saturated rect register.
module snn_mac_sat
    import snn_pkg::*;
#(
    parameter int ACC_W = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        issue,
    input  logic        sat_load,
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_b,
    output logic [10:0] rect
);

    logic signed [ACC_W-1:0] acc;
    logic signed [15:0]      prod;
    logic                    vld_d;

    assign prod = $signed(op_a) * $signed(op_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            vld_d <= 1'b0;
            rect  <= '0;
        end else begin
            vld_d <= issue;
            if (clr)
                acc <= '0;
            else if (vld_d)
                acc <= acc + ACC_W'(prod);
            if (sat_load)
                rect <= saturate(SAT_W'(acc));
        end
    end

endmodule

// File: rtl/snn_core_param.sv
// Parametrised N_IN-N_HID-N_OUT fully-connected inference engine with on-the-fly argmax.
// Optional macro SNN_SCORE_OUT_EN adds the per-class activation output 'score'.
module snn_core_param
    import snn_pkg::*;
#(
    parameter int N_IN   = 784,
    parameter int N_HID  = 32,
    parameter int N_OUT  = 10,
    parameter int ACC_W  = 26,
    parameter int IN_AW  = $clog2(N_IN),
    parameter int HID_AW = $clog2(N_HID),
    parameter int OUT_AW = $clog2(N_OUT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     q_in,
    output logic [IN_AW-1:0]         addr_in_unit,
    output logic [HID_AW+IN_AW-1:0]  hw_addr,
    input  logic [7:0]               hw_q,
    output logic [OUT_AW+HID_AW-1:0] ow_addr,
    input  logic [7:0]               ow_q,
    output logic [10:0]              lut_addr,
    input  logic [7:0]               lut_q,
    output logic                     busy,
    output logic                     done,
`ifdef SNN_SCORE_OUT_EN
    output logic [8*N_OUT-1:0]       score,
`endif
    output logic [OUT_AW-1:0]        digit
);

    localparam logic [IN_AW-1:0]  IN_LAST  = IN_AW'(N_IN - 1);
    localparam logic [HID_AW-1:0] HID_LAST = HID_AW'(N_HID - 1);
    localparam logic [OUT_AW-1:0] OUT_LAST = OUT_AW'(N_OUT - 1);

    state_t state, state_nx;

    logic [IN_AW-1:0]  in_idx;
    logic [HID_AW-1:0] hid_idx;
    logic [OUT_AW-1:0] out_idx;
    logic [7:0]        hidden [N_HID];
    logic [7:0]        hid_q;
    logic [7:0]        max_val;
    logic [OUT_AW-1:0] digit_r;
    logic              done_r;

    logic              issue, clr, sat_load, lut_sel, out_layer;
    logic [7:0]        op_a, op_b;
    logic [10:0]       rect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        clr      = 1'b0;
        sat_load = 1'b0;
        lut_sel  = 1'b0;
        case (state)
            IDLE: begin
                clr = 1'b1;
                if (start) state_nx = H_MAC;
            end
            H_MAC: begin
                issue = 1'b1;
                if (in_idx == IN_LAST) state_nx = H_DRAIN;
            end
            H_DRAIN: state_nx = H_SAT;
            H_SAT: begin
                sat_load = 1'b1;
                state_nx = H_LUT;
            end
            H_LUT: begin
                lut_sel  = 1'b1;
                state_nx = H_WR;
            end
            H_WR: begin
                clr      = 1'b1;
                state_nx = (hid_idx == HID_LAST) ? O_MAC : H_MAC;
            end
            O_MAC: begin
                issue = 1'b1;
                if (hid_idx == HID_LAST) state_nx = O_DRAIN;
            end
            O_DRAIN: state_nx = O_SAT;
            O_SAT: begin
                sat_load = 1'b1;
                state_nx = O_LUT;
            end
            O_LUT: begin
                lut_sel  = 1'b1;
                state_nx = O_WR;
            end
            O_WR: begin
                clr      = 1'b1;
                state_nx = (out_idx == OUT_LAST) ? DONE : O_MAC;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // hid_idx is the unit index in the hidden layer and the term index in the output layer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_idx  <= '0;
            hid_idx <= '0;
            out_idx <= '0;
            hid_q   <= '0;
            max_val <= '0;
            digit_r <= '0;
            done_r  <= 1'b0;
            for (int i = 0; i < N_HID; i++) hidden[i] <= '0;
        end else begin
            done_r <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        in_idx  <= '0;
                        hid_idx <= '0;
                        out_idx <= '0;
                        max_val <= '0;
                        digit_r <= '0;
                    end
                end
                H_MAC: in_idx <= (in_idx == IN_LAST) ? '0 : in_idx + 1'b1;
                H_WR: begin
                    hidden[hid_idx] <= lut_q;
                    hid_idx         <= (hid_idx == HID_LAST) ? '0 : hid_idx + 1'b1;
                end
                O_MAC: begin
                    hid_q   <= hidden[hid_idx];
                    hid_idx <= (hid_idx == HID_LAST) ? '0 : hid_idx + 1'b1;
                end
                O_WR: begin
                    if (lut_q > max_val) begin
                        max_val <= lut_q;
                        digit_r <= out_idx;
                    end
                    out_idx <= (out_idx == OUT_LAST) ? '0 : out_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_layer = (state == O_MAC) || (state == O_DRAIN);
    assign op_a      = out_layer ? hid_q : (q_in ? INPUT_ONE : 8'h00);
    assign op_b      = out_layer ? ow_q : hw_q;

    snn_mac_sat #(.ACC_W(ACC_W)) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .issue    (issue),
        .sat_load (sat_load),
        .op_a     (op_a),
        .op_b     (op_b),
        .rect     (rect)
    );

`ifdef SNN_SCORE_OUT_EN
    logic [8*N_OUT-1:0] score_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            score_r <= '0;
        else if ((state == IDLE) && start)
            score_r <= '0;
        else if (state == O_WR)
            score_r[8*out_idx +: 8] <= lut_q;
    end

    assign score = score_r;
`endif

    // Adding LUT_OFFSET maps the signed rect range onto the unsigned LUT index.
    assign lut_addr     = lut_sel ? (rect + 11'(LUT_OFFSET)) : '0;
    assign addr_in_unit = in_idx;
    assign hw_addr      = {hid_idx, in_idx};
    assign ow_addr      = {out_idx, hid_idx};
    assign busy         = (state != IDLE);
    assign done         = done_r;
    assign digit        = digit_r;

endmodule

// File: tb/tb_snn_core_param.sv
// Directed bench for snn_core_param: default, 16-4-3 and 4-2-8 instances
// backed by synchronous memory models with mode-selected contents.
module tb_snn_core_param;

    localparam int L_DEF   = 25577;
    localparam int L_SMALL = 105;
    localparam int L_TIE   = 65;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_drv = 1'b0;
    int   sel = 0;

    int n_checks = 0;
    int n_errors = 0;

    int q_mode = 0;
    int hw_mode = 0;
    int ow_mode = 0;
    int lut_mode = 0;

    int m_act [16];
    int m_digit;

    always #5 clk = ~clk;

    // ---------------- instance signals ----------------
    logic        s0_start, s0_q_in, s0_busy, s0_done;
    logic [9:0]  s0_addr_in;
    logic [14:0] s0_hw_addr;
    logic [8:0]  s0_ow_addr;
    logic [7:0]  s0_hw_q, s0_ow_q, s0_lut_q;
    logic [10:0] s0_lut_addr;
    logic [3:0]  s0_digit;

    logic        s1_start, s1_q_in, s1_busy, s1_done;
    logic [3:0]  s1_addr_in;
    logic [5:0]  s1_hw_addr;
    logic [3:0]  s1_ow_addr;
    logic [7:0]  s1_hw_q, s1_ow_q, s1_lut_q;
    logic [10:0] s1_lut_addr;
    logic [1:0]  s1_digit;

    logic        s2_start, s2_q_in, s2_busy, s2_done;
    logic [1:0]  s2_addr_in;
    logic [2:0]  s2_hw_addr;
    logic [3:0]  s2_ow_addr;
    logic [7:0]  s2_hw_q, s2_ow_q, s2_lut_q;
    logic [10:0] s2_lut_addr;
    logic [2:0]  s2_digit;

`ifdef SNN_SCORE_OUT_EN
    logic [79:0] s0_score;
    logic [23:0] s1_score;
    logic [63:0] s2_score;
`endif

    assign s0_start = start_drv && (sel == 0);
    assign s1_start = start_drv && (sel == 1);
    assign s2_start = start_drv && (sel == 2);

    logic        m_busy, m_done;
    logic [3:0]  m_digit_sig;
    logic [10:0] m_lut_addr;

    always_comb begin
        case (sel)
            0: begin
                m_busy = s0_busy; m_done = s0_done; m_digit_sig = s0_digit; m_lut_addr = s0_lut_addr;
            end
            1: begin
                m_busy = s1_busy; m_done = s1_done; m_digit_sig = {2'b00, s1_digit}; m_lut_addr = s1_lut_addr;
            end
            default: begin
                m_busy = s2_busy; m_done = s2_done; m_digit_sig = {1'b0, s2_digit}; m_lut_addr = s2_lut_addr;
            end
        endcase
    end

    // ---------------- memory content functions ----------------
    function automatic logic q_fn(input int i);
        return (q_mode == 0) ? 1'b1 : ((i % 3) == 0);
    endfunction

    function automatic logic [7:0] hw_fn(input int h, input int i);
        int v;
        case (hw_mode)
            0:       v = 1;
            1:       v = 127;
            2:       v = -128;
            default: v = ((h * 3 + i) % 5) - 2;
        endcase
        return 8'(v);
    endfunction

    function automatic logic [7:0] ow_fn(input int o, input int h);
        int v;
        case (ow_mode)
            0:       v = (o == 3) ? 1 : 0;
            1:       v = (o == 2 || o == 7) ? 127 : 0;
            default: v = ((o * 5 + h) % 7) - 3;
        endcase
        return 8'(v);
    endfunction

    function automatic logic [7:0] lut_fn(input int a);
        logic [7:0] v;
        case (lut_mode)
            0:       v = 8'(a);
            1:       v = 8'h00;
            default: v = 8'(a >> 4);
        endcase
        return v;
    endfunction

    always @(posedge clk) begin
        s0_q_in  <= q_fn(int'(s0_addr_in));
        s0_hw_q  <= hw_fn(int'(s0_hw_addr[14:10]), int'(s0_hw_addr[9:0]));
        s0_ow_q  <= ow_fn(int'(s0_ow_addr[8:5]), int'(s0_ow_addr[4:0]));
        s0_lut_q <= lut_fn(int'(s0_lut_addr));
        s1_q_in  <= q_fn(int'(s1_addr_in));
        s1_hw_q  <= hw_fn(int'(s1_hw_addr[5:4]), int'(s1_hw_addr[3:0]));
        s1_ow_q  <= ow_fn(int'(s1_ow_addr[3:2]), int'(s1_ow_addr[1:0]));
        s1_lut_q <= lut_fn(int'(s1_lut_addr));
        s2_q_in  <= q_fn(int'(s2_addr_in));
        s2_hw_q  <= hw_fn(int'(s2_hw_addr[2]), int'(s2_hw_addr[1:0]));
        s2_ow_q  <= ow_fn(int'(s2_ow_addr[3:1]), int'(s2_ow_addr[0]));
        s2_lut_q <= lut_fn(int'(s2_lut_addr));
    end

    // ---------------- DUTs ----------------
    snn_core_param d0 (
        .clk(clk), .rst_n(rst_n), .start(s0_start), .q_in(s0_q_in),
        .addr_in_unit(s0_addr_in), .hw_addr(s0_hw_addr), .hw_q(s0_hw_q),
        .ow_addr(s0_ow_addr), .ow_q(s0_ow_q), .lut_addr(s0_lut_addr), .lut_q(s0_lut_q),
        .busy(s0_busy), .done(s0_done),
`ifdef SNN_SCORE_OUT_EN
        .score(s0_score),
`endif
        .digit(s0_digit)
    );

    snn_core_param #(.N_IN(16), .N_HID(4), .N_OUT(3)) d1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .q_in(s1_q_in),
        .addr_in_unit(s1_addr_in), .hw_addr(s1_hw_addr), .hw_q(s1_hw_q),
        .ow_addr(s1_ow_addr), .ow_q(s1_ow_q), .lut_addr(s1_lut_addr), .lut_q(s1_lut_q),
        .busy(s1_busy), .done(s1_done),
`ifdef SNN_SCORE_OUT_EN
        .score(s1_score),
`endif
        .digit(s1_digit)
    );

    snn_core_param #(.N_IN(4), .N_HID(2), .N_OUT(8)) d2 (
        .clk(clk), .rst_n(rst_n), .start(s2_start), .q_in(s2_q_in),
        .addr_in_unit(s2_addr_in), .hw_addr(s2_hw_addr), .hw_q(s2_hw_q),
        .ow_addr(s2_ow_addr), .ow_q(s2_ow_q), .lut_addr(s2_lut_addr), .lut_q(s2_lut_q),
        .busy(s2_busy), .done(s2_done),
`ifdef SNN_SCORE_OUT_EN
        .score(s2_score),
`endif
        .digit(s2_digit)
    );

    // ---------------- golden model ----------------
    function automatic int sx8(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    function automatic int lut_index(input longint acc);
        longint r;
        if (acc > 131071)       r = 1023;
        else if (acc < -131072) r = -1024;
        else                    r = acc >>> 7;
        return int'(r + 1024);
    endfunction

    task automatic model_run(input int ni, input int nh, input int no);
        int     hid [64];
        longint acc;
        int     best;
        for (int h = 0; h < nh; h++) begin
            acc = 0;
            for (int i = 0; i < ni; i++)
                acc += longint'((q_fn(i) ? 127 : 0) * sx8(hw_fn(h, i)));
            hid[h] = int'(lut_fn(lut_index(acc)));
        end
        best    = 0;
        m_digit = 0;
        for (int o = 0; o < no; o++) begin
            acc = 0;
            for (int h = 0; h < nh; h++)
                acc += longint'(sx8(8'(hid[h])) * sx8(ow_fn(o, h)));
            m_act[o] = int'(lut_fn(lut_index(acc)));
            if (m_act[o] > best) begin
                best    = m_act[o];
                m_digit = o;
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    // Window n is the cycle after the n-th clock edge following the start-sampling edge.
    task automatic run_inst(input int style, input int budget, input int probe_n,
                            output int lat, output int n_done, output logic [10:0] probe);
        int n, h, r, k, o;
        lat    = -1;
        n_done = 0;
        probe  = '0;
        n      = 0;
        @(negedge clk);
        start_drv = 1'b1;
        @(posedge clk);
        #1;
        if (style == 0) start_drv = 1'b0;
        while (n < budget && !(lat >= 0 && n > lat + 20)) begin
            if (n == probe_n) probe = m_lut_addr;
            if (m_done) begin
                n_done++;
                if (lat < 0) lat = n;
            end
            if (sel == 1) begin
                if (n < 80) begin
                    h = n / 20;
                    r = n % 20;
                    if (r < 16) begin
                        n_checks++;
                        if (s1_hw_addr !== 6'(h * 16 + r) || s1_addr_in !== 4'(r)) begin
                            n_errors++;
                            $display("FAIL small_hw_addr n=%0d: got hw=%0d in=%0d want hw=%0d in=%0d",
                                     n, s1_hw_addr, s1_addr_in, h * 16 + r, r);
                        end
                    end
                end else if (n < 104) begin
                    k = n - 80;
                    o = k / 8;
                    r = k % 8;
                    if (r < 4) begin
                        n_checks++;
                        if (s1_ow_addr !== 4'(o * 4 + r)) begin
                            n_errors++;
                            $display("FAIL small_ow_addr n=%0d: got %0d want %0d", n, s1_ow_addr, o * 4 + r);
                        end
                    end
                end
            end
            if (style == 1) begin
                if (n == 100)  start_drv = 1'b0;
                if (n == 1000) start_drv = 1'b1;
                if (n == 1001) start_drv = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start_drv = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sel   = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (s0_busy !== 1'b0 || s0_done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got busy=%b done=%b want 0 0", s0_busy, s0_done);
        end
        n_checks++;
        if (s0_digit !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_digit: got %0d want 0", s0_digit);
        end
        n_checks++;
        if (s0_addr_in !== 10'd0 || s0_hw_addr !== 15'd0 || s0_ow_addr !== 9'd0 || s0_lut_addr !== 11'd0) begin
            n_errors++;
            $display("FAIL reset_addr: got in=%0d hw=%0d ow=%0d lut=%0d want all 0",
                     s0_addr_in, s0_hw_addr, s0_ow_addr, s0_lut_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_default_run();
        int lat, nd;
        logic [10:0] probe;
        sel = 0; q_mode = 0; hw_mode = 0; ow_mode = 0; lut_mode = 0;
        run_inst(0, L_DEF + 100, 786, lat, nd, probe);
        n_checks++;
        if (lat != L_DEF) begin
            n_errors++;
            $display("FAIL default_latency: got %0d want %0d", lat, L_DEF);
        end
        n_checks++;
        if (nd != 1) begin
            n_errors++;
            $display("FAIL default_done_count: got %0d want 1", nd);
        end
        // 784*127 = 99568 -> rect 777 -> 777+1024
        n_checks++;
        if (probe !== 11'h709) begin
            n_errors++;
            $display("FAIL default_h_lut_addr: got %h want 709", probe);
        end
        n_checks++;
        if (m_digit_sig !== 4'd3 || m_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL default_digit: got digit=%0d busy=%b want 3 0", m_digit_sig, m_busy);
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (m_digit_sig !== 4'd3) begin
            n_errors++;
            $display("FAIL default_digit_hold: got %0d want 3", m_digit_sig);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, nd;
        logic [10:0] probe;
        bit seen_done, seen_busy;
        sel = 0;
        run_inst(0, 500, -1, lat, nd, probe);
        n_checks++;
        if (nd != 0) begin
            n_errors++;
            $display("FAIL midrun_early_done: got %0d want 0", nd);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (s0_busy !== 1'b0 || s0_done !== 1'b0 || s0_digit !== 4'd0) begin
            n_errors++;
            $display("FAIL midrun_reset: got busy=%b done=%b digit=%0d want 0 0 0", s0_busy, s0_done, s0_digit);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        seen_busy = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (s0_done) seen_done = 1'b1;
            if (s0_busy) seen_busy = 1'b1;
        end
        n_checks++;
        if (seen_done || seen_busy) begin
            n_errors++;
            $display("FAIL midrun_after_reset: got done_seen=%b busy_seen=%b want 0 0", seen_done, seen_busy);
        end
    endtask

    task automatic test_start_ignored();
        int lat, nd;
        logic [10:0] probe;
        sel = 0; q_mode = 0; hw_mode = 0; ow_mode = 0; lut_mode = 0;
        run_inst(1, L_DEF + 100, -1, lat, nd, probe);
        n_checks++;
        if (lat != L_DEF || nd != 1) begin
            n_errors++;
            $display("FAIL start_held: got latency=%0d dones=%0d want %0d 1", lat, nd, L_DEF);
        end
        n_checks++;
        if (m_digit_sig !== 4'd3 || m_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL start_held_digit: got digit=%0d busy=%b want 3 0", m_digit_sig, m_busy);
        end
    endtask

    task automatic test_saturation();
        int lat, nd;
        logic [10:0] probe;
        sel = 0; q_mode = 0; ow_mode = 0; lut_mode = 0;
        hw_mode = 1;
        run_inst(0, 790, 786, lat, nd, probe);
        n_checks++;
        if (probe !== 11'h7FF) begin
            n_errors++;
            $display("FAIL sat_positive: got %h want 7ff", probe);
        end
        do_reset();
        hw_mode = 2;
        run_inst(0, 790, 786, lat, nd, probe);
        n_checks++;
        if (probe !== 11'h000) begin
            n_errors++;
            $display("FAIL sat_negative: got %h want 000", probe);
        end
        do_reset();
    endtask

    task automatic test_small_param();
        int lat, nd;
        logic [10:0] probe;
        sel = 1; q_mode = 1; hw_mode = 3; ow_mode = 2; lut_mode = 2;
        model_run(16, 4, 3);
        run_inst(0, 300, -1, lat, nd, probe);
        n_checks++;
        if (lat != L_SMALL || nd != 1) begin
            n_errors++;
            $display("FAIL small_latency: got latency=%0d dones=%0d want %0d 1", lat, nd, L_SMALL);
        end
        n_checks++;
        if (m_digit_sig !== 4'(m_digit)) begin
            n_errors++;
            $display("FAIL small_digit: got %0d want %0d", m_digit_sig, m_digit);
        end
`ifdef SNN_SCORE_OUT_EN
        for (int o = 0; o < 3; o++) begin
            n_checks++;
            if (s1_score[8*o +: 8] !== 8'(m_act[o])) begin
                n_errors++;
                $display("FAIL small_score[%0d]: got %0d want %0d", o, s1_score[8*o +: 8], m_act[o]);
            end
        end
`endif
    endtask

    task automatic test_tie_and_zero();
        int lat, nd;
        logic [10:0] probe;
        sel = 2; q_mode = 0; hw_mode = 1; ow_mode = 1; lut_mode = 2;
        run_inst(0, 200, -1, lat, nd, probe);
        n_checks++;
        if (lat != L_TIE || nd != 1) begin
            n_errors++;
            $display("FAIL tie_latency: got latency=%0d dones=%0d want %0d 1", lat, nd, L_TIE);
        end
        // outputs 2 and 7 both reach 75, all others 64
        n_checks++;
        if (m_digit_sig !== 4'd2) begin
            n_errors++;
            $display("FAIL tie_digit: got %0d want 2", m_digit_sig);
        end
`ifdef SNN_SCORE_OUT_EN
        n_checks++;
        if (s2_score[8*7 +: 8] !== 8'd75 || s2_score[8*2 +: 8] !== 8'd75 || s2_score[0 +: 8] !== 8'd64) begin
            n_errors++;
            $display("FAIL tie_score: got s7=%0d s2=%0d s0=%0d want 75 75 64",
                     s2_score[8*7 +: 8], s2_score[8*2 +: 8], s2_score[0 +: 8]);
        end
`endif
        lut_mode = 1;
        run_inst(0, 200, -1, lat, nd, probe);
        n_checks++;
        if (m_digit_sig !== 4'd0 || nd != 1) begin
            n_errors++;
            $display("FAIL zero_lut_digit: got digit=%0d dones=%0d want 0 1", m_digit_sig, nd);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_default_run();
        test_reset_mid_run();
        test_start_ignored();
        test_saturation();
        test_small_param();
        test_tie_and_zero();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
